// File: rtl/quiz_round_if.sv
// Operator/front-end signal bundle for the quiz round controller.
// The bench drives it through master and the controller sits on slave.
interface quiz_round_if #(
    parameter int SEL_W   = 3,
    parameter int ROUND_W = 8
);
    logic [SEL_W-1:0]   SEL_IN;
    logic               DEC_IN;
    logic               CLR_IN;
    logic               VIEW_BTN;
    logic               OK_IN;
    logic               QUE_RDY;
    logic [1:0]         JUDG_IN;
    logic               WRONG_IN;
    logic [1:0]         HP_IN;

    logic [3:0]         STATE;
    logic               READY_OUT;
    logic [SEL_W-1:0]   SEL_OUT;
    logic               DEC_OUT;
    logic               CLR_OUT;
    logic [7:0]         TIME_LEFT;
    logic [ROUND_W-1:0] ROUND;

    modport master (
        output SEL_IN, DEC_IN, CLR_IN, VIEW_BTN, OK_IN, QUE_RDY, JUDG_IN, WRONG_IN, HP_IN,
        input  STATE, READY_OUT, SEL_OUT, DEC_OUT, CLR_OUT, TIME_LEFT, ROUND
    );

    modport slave (
        input  SEL_IN, DEC_IN, CLR_IN, VIEW_BTN, OK_IN, QUE_RDY, JUDG_IN, WRONG_IN, HP_IN,
        output STATE, READY_OUT, SEL_OUT, DEC_OUT, CLR_OUT, TIME_LEFT, ROUND
    );
endinterface

// File: rtl/quiz_round_ctrl.sv
// Round sequencer for the two-player factorization quiz: answer window with
// countdown, timed result display, button edge detection and round counting.
module quiz_round_ctrl #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int HOLD_SEC   = 1,
    parameter int ANSWER_SEC = 30,
    parameter int SEL_W      = 3,
    parameter int ROUND_W    = 8
) (
    input  logic        CLK,
    input  logic        RST,
    quiz_round_if.slave bus
);
    localparam int          TICK_W = $clog2(TICK_DIV);
    localparam int          HOLD_W = $clog2(HOLD_SEC + 1);
    localparam logic [7:0]  ANS    = 8'(ANSWER_SEC);

    typedef enum logic [3:0] {
        S_READY    = 4'h2,
        S_QUESTION = 4'h3,
        S_INPUT    = 4'h4,
        S_TIMEOUT  = 4'h5,
        S_DRAW     = 4'h6,
        S_WRONG    = 4'h7,
        S_GOOD     = 4'h8,
        S_OUCH     = 4'h9,
        S_WIN      = 4'hA,
        S_LOSE     = 4'hB
    } state_t;

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tick_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [7:0]         time_left;
    logic [ROUND_W-1:0] round_cnt;

    logic [SEL_W-1:0]   sel_prev_p0;
    logic               dec_prev_p0, clr_prev_p0, view_prev_p0;
    logic [SEL_W-1:0]   sel_pls_p1;
    logic               dec_pls_p1, clr_pls_p1;
    logic [3:0]         state_out_p1;
    logic               ready_p1;

    logic [SEL_W-1:0]   sel_edge;
    logic               dec_edge, clr_edge, view_edge;
    logic               tick, in_window, is_result, timeout, hold_done;

    function automatic logic [7:0] sat_dec(input logic [7:0] v);
        return (v == 8'd0) ? 8'd0 : v - 8'd1;
    endfunction

    assign sel_edge  = bus.SEL_IN & ~sel_prev_p0;
    assign dec_edge  = bus.DEC_IN & ~dec_prev_p0;
    assign clr_edge  = bus.CLR_IN & ~clr_prev_p0;
    assign view_edge = bus.VIEW_BTN & ~view_prev_p0;

    // tick_cnt is held at zero in READY, so no tick can fire there
    assign tick      = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign in_window = (state_q == S_QUESTION) || (state_q == S_INPUT) || (state_q == S_WRONG);
    assign is_result = (state_q == S_TIMEOUT) || (state_q == S_DRAW) || (state_q == S_WRONG) ||
                       (state_q == S_GOOD) || (state_q == S_OUCH) || (state_q == S_WIN) ||
                       (state_q == S_LOSE);
    assign timeout   = in_window && tick && (time_left == 8'd1);
    assign hold_done = is_result && tick && (hold_cnt == HOLD_W'(HOLD_SEC - 1));

    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_READY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_READY:    if (bus.OK_IN && bus.QUE_RDY) state_d = S_QUESTION;
            S_QUESTION: begin
                if (timeout)           state_d = S_TIMEOUT;
                else if (!bus.QUE_RDY) state_d = S_READY;
                else if (view_edge)    state_d = S_INPUT;
            end
            S_INPUT: begin
                if (timeout)                  state_d = S_TIMEOUT;
                else if (bus.JUDG_IN == 2'b11) state_d = S_DRAW;
                else if (bus.JUDG_IN == 2'b01) state_d = S_GOOD;
                else if (bus.JUDG_IN == 2'b10) state_d = S_OUCH;
                else if (bus.WRONG_IN)         state_d = S_WRONG;
                else if (view_edge)            state_d = S_QUESTION;
            end
            S_WRONG: begin
                if (timeout)        state_d = S_TIMEOUT;
                else if (hold_done) state_d = S_INPUT;
            end
            S_GOOD: begin
                if (bus.HP_IN == 2'b01) state_d = S_WIN;
                else if (hold_done)     state_d = S_READY;
            end
            S_OUCH: begin
                if (bus.HP_IN == 2'b10) state_d = S_LOSE;
                else if (hold_done)     state_d = S_READY;
            end
            S_TIMEOUT, S_DRAW, S_WIN, S_LOSE: if (hold_done) state_d = S_READY;
            default: state_d = S_READY;
        endcase
    end

    // p0: raw button history, timers and round count
    always_ff @(posedge CLK) begin
        if (RST) begin
            sel_prev_p0  <= '0;
            dec_prev_p0  <= 1'b0;
            clr_prev_p0  <= 1'b0;
            view_prev_p0 <= 1'b0;
            tick_cnt     <= '0;
            hold_cnt     <= '0;
            time_left    <= ANS;
            round_cnt    <= '0;
        end else begin
            sel_prev_p0  <= bus.SEL_IN;
            dec_prev_p0  <= bus.DEC_IN;
            clr_prev_p0  <= bus.CLR_IN;
            view_prev_p0 <= bus.VIEW_BTN;

            if ((state_d != state_q) || (state_q == S_READY) || tick) tick_cnt <= '0;
            else                                                      tick_cnt <= tick_cnt + 1'b1;

            if (state_d != state_q)    hold_cnt <= '0;
            else if (is_result && tick) hold_cnt <= hold_cnt + 1'b1;

            if ((state_q == S_READY) && (state_d == S_QUESTION)) time_left <= ANS;
            else if (in_window && tick)                           time_left <= sat_dec(time_left);

            // a finished match (WIN/LOSE) restarts the round count
            if ((state_d == S_READY) && is_result)
                round_cnt <= ((state_q == S_WIN) || (state_q == S_LOSE)) ? '0 : round_cnt + 1'b1;
        end
    end

    // p1: registered status and operator pulses gated to INPUT
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_out_p1 <= 4'h2;
            ready_p1     <= 1'b1;
            sel_pls_p1   <= '0;
            dec_pls_p1   <= 1'b0;
            clr_pls_p1   <= 1'b0;
        end else begin
            state_out_p1 <= state_q;
            ready_p1     <= (state_q == S_READY);
            sel_pls_p1   <= (state_q == S_INPUT) ? sel_edge : '0;
            dec_pls_p1   <= (state_q == S_INPUT) && dec_edge;
            clr_pls_p1   <= (state_q == S_INPUT) && clr_edge;
        end
    end

    assign bus.STATE     = state_out_p1;
    assign bus.READY_OUT = ready_p1;
    assign bus.SEL_OUT   = sel_pls_p1;
    assign bus.DEC_OUT   = dec_pls_p1;
    assign bus.CLR_OUT   = clr_pls_p1;
    assign bus.TIME_LEFT = time_left;
    assign bus.ROUND     = round_cnt;
endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Bench for quiz_round_ctrl: directed round scenarios followed by random
// operator traffic, all compared every cycle against a behavioural model.
module tb_quiz_round_ctrl;
    localparam int TD = 4;
    localparam int HS = 1;
    localparam int AS = 3;
    localparam int SW = 3;
    localparam int RW = 8;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    quiz_round_if #(.SEL_W(SW), .ROUND_W(RW)) bus ();

    quiz_round_ctrl #(
        .TICK_DIV(TD), .HOLD_SEC(HS), .ANSWER_SEC(AS), .SEL_W(SW), .ROUND_W(RW)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // model: state code, cycles spent in it, seconds left, rounds played
    int          m_state = 2, m_age = 0, m_time = AS, m_round = 0;
    logic [SW-1:0] m_psel = '0;
    logic        m_pdec = 0, m_pclr = 0, m_pview = 0;
    int          e_state = 2;
    logic        e_ready = 1;
    logic [SW-1:0] e_sel = '0;
    logic        e_dec = 0, e_clr = 0;

    function automatic bit is_res(input int s);
        return (s >= 5) && (s <= 11);
    endfunction

    function automatic bit in_win(input int s);
        return (s == 3) || (s == 4) || (s == 7);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int nxt;
        bit tk, hd, to, vp;
        if (RST) begin
            m_state = 2; m_age = 0; m_time = AS; m_round = 0;
            m_psel = '0; m_pdec = 0; m_pclr = 0; m_pview = 0;
            e_state = 2; e_ready = 1; e_sel = '0; e_dec = 0; e_clr = 0;
            return;
        end
        tk = (m_state != 2) && ((m_age % TD) == TD - 1);
        hd = is_res(m_state) && (m_age == HS * TD - 1);
        to = in_win(m_state) && tk && (m_time == 1);
        vp = bus.VIEW_BTN && !m_pview;
        nxt = m_state;
        case (m_state)
            2: if (bus.OK_IN && bus.QUE_RDY) nxt = 3;
            3: if (to) nxt = 5; else if (!bus.QUE_RDY) nxt = 2; else if (vp) nxt = 4;
            4: begin
                if (to) nxt = 5;
                else if (bus.JUDG_IN == 2'd3) nxt = 6;
                else if (bus.JUDG_IN == 2'd1) nxt = 8;
                else if (bus.JUDG_IN == 2'd2) nxt = 9;
                else if (bus.WRONG_IN) nxt = 7;
                else if (vp) nxt = 3;
            end
            7: if (to) nxt = 5; else if (hd) nxt = 4;
            8: if (bus.HP_IN == 2'd1) nxt = 10; else if (hd) nxt = 2;
            9: if (bus.HP_IN == 2'd2) nxt = 11; else if (hd) nxt = 2;
            default: if (hd) nxt = 2;
        endcase
        e_state = m_state;
        e_ready = (m_state == 2);
        e_sel   = (m_state == 4) ? (bus.SEL_IN & ~m_psel) : '0;
        e_dec   = (m_state == 4) && bus.DEC_IN && !m_pdec;
        e_clr   = (m_state == 4) && bus.CLR_IN && !m_pclr;
        if (m_state == 2 && nxt == 3) m_time = AS;
        else if (in_win(m_state) && tk && m_time > 0) m_time = m_time - 1;
        if (nxt == 2 && is_res(m_state))
            m_round = (m_state >= 10) ? 0 : (m_round + 1) % (1 << RW);
        m_age   = (nxt == m_state) ? m_age + 1 : 0;
        m_state = nxt;
        m_psel = bus.SEL_IN; m_pdec = bus.DEC_IN; m_pclr = bus.CLR_IN; m_pview = bus.VIEW_BTN;
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
        chk("STATE", bus.STATE, e_state);
        chk("READY_OUT", bus.READY_OUT, e_ready);
        chk("SEL_OUT", bus.SEL_OUT, e_sel);
        chk("DEC_OUT", bus.DEC_OUT, e_dec);
        chk("CLR_OUT", bus.CLR_OUT, e_clr);
        chk("TIME_LEFT", bus.TIME_LEFT, m_time);
        chk("ROUND", bus.ROUND, m_round);
    endtask

    task automatic wait_state(input logic [3:0] code, input int budget);
        int n = 0;
        while (bus.STATE !== code && n < budget) begin
            step();
            n++;
        end
        chk("wait_state", bus.STATE, code);
    endtask

    task automatic pulse_view();
        bus.VIEW_BTN = 1; step(); bus.VIEW_BTN = 0;
    endtask

    task automatic start_round();
        bus.OK_IN = 1; bus.QUE_RDY = 1;
        wait_state(4'h3, 8);
        bus.OK_IN = 0;
        pulse_view();
        wait_state(4'h4, 4);
    endtask

    initial begin
        RST = 1;
        bus.SEL_IN = '0; bus.DEC_IN = 0; bus.CLR_IN = 0; bus.VIEW_BTN = 0;
        bus.OK_IN = 0; bus.QUE_RDY = 0; bus.JUDG_IN = 2'd0; bus.WRONG_IN = 0; bus.HP_IN = 2'd0;
        step(); step();
        chk("rst_state", bus.STATE, 4'h2);
        chk("rst_ready", bus.READY_OUT, 1'b1);
        chk("rst_time", bus.TIME_LEFT, 8'd3);
        chk("rst_round", bus.ROUND, 8'd0);
        RST = 0;

        // held view button enters INPUT once; decide edge gives one pulse
        bus.OK_IN = 1; bus.QUE_RDY = 1;
        wait_state(4'h3, 8);
        bus.OK_IN = 0; bus.VIEW_BTN = 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) bus.DEC_IN = 1;
            step();
        end
        bus.VIEW_BTN = 0; bus.DEC_IN = 0;
        wait_state(4'h2, 60);

        // wrong answer, then judge beats wrong, then match won
        start_round();
        bus.WRONG_IN = 1; step(); bus.WRONG_IN = 0;
        wait_state(4'h7, 4);
        wait_state(4'h4, 8);
        bus.WRONG_IN = 1; bus.JUDG_IN = 2'd1; step(); bus.WRONG_IN = 0; bus.JUDG_IN = 2'd0;
        wait_state(4'h8, 4);
        bus.HP_IN = 2'd1; step(); bus.HP_IN = 2'd0;
        wait_state(4'hA, 4);
        bus.SEL_IN = 3'b101; step(); bus.SEL_IN = '0; step(); bus.SEL_IN = 3'b010; step(); bus.SEL_IN = '0;
        wait_state(4'h2, 12);
        chk("win_round_clear", bus.ROUND, 8'd0);

        // answer window expires with only operator pulses
        start_round();
        bus.CLR_IN = 1; step(); bus.CLR_IN = 0;
        bus.SEL_IN = 3'b011; step(); bus.SEL_IN = '0;
        wait_state(4'h5, 16);
        wait_state(4'h2, 8);
        chk("timeout_round", bus.ROUND, 8'd1);

        // reset in the middle of OUCH
        start_round();
        bus.JUDG_IN = 2'd2; step(); bus.JUDG_IN = 2'd0;
        wait_state(4'h9, 4);
        RST = 1; step(); RST = 0;
        chk("mid_rst_state", bus.STATE, 4'h2);
        chk("mid_rst_time", bus.TIME_LEFT, 8'd3);
        chk("mid_rst_round", bus.ROUND, 8'd0);
        chk("mid_rst_gated", {bus.SEL_OUT, bus.DEC_OUT, bus.CLR_OUT}, '0);

        // random operator traffic
        for (int i = 0; i < 1500; i++) begin
            RST          = ($urandom_range(0, 299) == 0);
            bus.OK_IN    = ($urandom_range(0, 3) == 0);
            bus.QUE_RDY  = ($urandom_range(0, 15) != 0);
            bus.VIEW_BTN = ($urandom_range(0, 5) == 0) ? ~bus.VIEW_BTN : bus.VIEW_BTN;
            bus.DEC_IN   = ($urandom_range(0, 3) == 0) ? ~bus.DEC_IN : bus.DEC_IN;
            bus.CLR_IN   = ($urandom_range(0, 3) == 0) ? ~bus.CLR_IN : bus.CLR_IN;
            bus.SEL_IN   = ($urandom_range(0, 2) == 0) ? SW'($urandom) : bus.SEL_IN;
            bus.JUDG_IN  = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            bus.WRONG_IN = ($urandom_range(0, 9) == 0);
            bus.HP_IN    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/quiz_round_ctrl.md
Name: quiz_round_ctrl

Overview:
Parametrised next-generation round controller for the two-player factorization quiz.
- Sequences each round: READY -> QUESTION/INPUT -> result display -> READY.
- Adds an answer time limit with countdown, configurable result-hold time, proper rising-edge button detection and a round counter.
- Sits between the button/ready front-end and the input, judge and HP modules; gates operator inputs to the input module only while in INPUT.

Parameters:
TICK_DIV, 50_000_000, CLK cycles per 1 s tick (minimum 2)
HOLD_SEC, 1, seconds each result state (WRONG/GOOD/OUCH/DRAW/WIN/LOSE/TIMEOUT) is held
ANSWER_SEC, 30, seconds allowed per question (1..255)
SEL_W, 3, width of selector button bus
ROUND_W, 8, round counter width

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
SEL_IN  in  SEL_W  raw selector buttons (level)
DEC_IN  in  1  raw decide button
CLR_IN  in  1  raw clear button
VIEW_BTN  in  1  raw question/input view toggle button
OK_IN  in  1  both players pressed start (level)
QUE_RDY  in  1  question loaded in input module
JUDG_IN  in  2  00 none, 01 we scored, 10 opponent scored, 11 both
WRONG_IN  in  1  our answer rejected (pulse)
HP_IN  in  2  00 none, 01 we won match, 10 opponent won match
STATE  out  4  current state code
READY_OUT  out  1  high while in READY
SEL_OUT  out  SEL_W  rising-edge pulses of SEL_IN, INPUT only, else 0
DEC_OUT  out  1  rising-edge pulse of DEC_IN, INPUT only, else 0
CLR_OUT  out  1  rising-edge pulse of CLR_IN, INPUT only, else 0
TIME_LEFT  out  8  seconds remaining in answer window
ROUND  out  ROUND_W  completed-round count

Behaviour:
- All logic on posedge CLK. RST has priority over everything: state READY; all counters, edge registers and the view bit cleared; STATE=4'h2, READY_OUT=1, SEL_OUT/DEC_OUT/CLR_OUT=0, TIME_LEFT=ANSWER_SEC, ROUND=0.
- State codes: READY 2, QUESTION 3, INPUT 4, TIMEOUT 5, DRAW 6, WRONG 7, GOOD 8, OUCH 9, WIN A, LOSE B. STATE and READY_OUT are registered from the current state, so they lag it by one cycle.
- Edge detect: each raw button has a registered previous value; pulse = raw & ~prev. A held button produces exactly one pulse.
- Gated pulses (SEL_OUT, DEC_OUT, CLR_OUT) are registered: 1-cycle latency after the edge.
- Tick: counter 0..TICK_DIV-1 runs only in QUESTION, INPUT and result states; it is zeroed on every state change and in READY. tick = (count==TICK_DIV-1).
- Hold counter: counts ticks in result states; hold_done when it reaches HOLD_SEC; zeroed on state change.
- READY: OK_IN & QUE_RDY -> QUESTION. On entry: view bit cleared, TIME_LEFT loaded with ANSWER_SEC.
- QUESTION/INPUT share the answer window. Each tick decrements TIME_LEFT (saturating at 0).
  - Transition at TIME_LEFT==1 & tick -> TIMEOUT.
- QUESTION:
  - VIEW_BTN pulse & QUE_RDY toggles the view bit -> INPUT.
  - ~QUE_RDY -> READY (question withdrawn).
- INPUT, priority order:
  1. timeout
  2. JUDG_IN 11 -> DRAW
  3. 01 -> GOOD
  4. 10 -> OUCH
  5. WRONG_IN -> WRONG
  6. VIEW_BTN pulse -> QUESTION
  - Judge results beat WRONG_IN when both occur in the same cycle.
- WRONG: hold_done -> INPUT. TIME_LEFT keeps counting down, and timeout still applies.
- GOOD: HP_IN==01 -> WIN (checked before hold_done); else hold_done -> READY.
- OUCH: HP_IN==10 -> LOSE; else hold_done -> READY.
- DRAW, TIMEOUT, WIN, LOSE: hold_done -> READY.
- ROUND increments by 1 on every transition into READY from a result state. It wraps modulo 2^ROUND_W. Reset clears it.
- WIN/LOSE -> READY also clears ROUND (new match).
- Undefined state encodings recover to READY on the next cycle.

Test Plan:
- Reset with TICK_DIV=4, HOLD_SEC=1, ANSWER_SEC=3 -> STATE=2, READY_OUT=1, TIME_LEFT=3, ROUND=0.
- OK_IN=1, QUE_RDY=1 -> STATE=3; VIEW_BTN held 10 cycles -> STATE=4 exactly once, no toggle back; DEC_IN rising -> single 1-cycle DEC_OUT pulse.
- In INPUT, WRONG_IN pulse -> STATE=7 for 4 cycles, back to 4; same-cycle JUDG_IN=01 and WRONG_IN -> STATE=8.
- In INPUT, no input for 12 cycles -> TIME_LEFT 3,2,1, then STATE=5 for 4 cycles -> STATE=2, ROUND=1.
- In GOOD, HP_IN=01 -> STATE=A, hold 4 cycles -> STATE=2, ROUND=0; SEL_IN pulses outside INPUT -> SEL_OUT stays 0.
- RST asserted mid-OUCH -> next cycle STATE=2, TIME_LEFT=3, ROUND=0, gated outputs 0.
